// File: rtl/shapool_host_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shapool_host_spi_pkg
// Description : Shared definitions for the shapool host-side SPI initiator:
//               controller state encoding, SPI mode and default word widths
//               (must match the device-side shapool parameters).
// Revision    : 1.0 - initial release
// ============================================================================
package shapool_host_spi_pkg;

    // Controller sequence: one job load, a settle gap, wait for READY, readback
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_GAP        = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_READ       = 3'd4,
        ST_DONE       = 3'd5
    } host_state_t;

    // Mode 0: CPOL=0 (SCK idles low), CPHA=0 (device samples on rising edge)
    localparam logic [1:0] c_spi_mode = 2'd0;

    // 256-bit midstate + 96-bit header tail
    localparam int c_default_job_bits   = 352;
    // 32-bit nonce + 8-bit device index
    localparam int c_default_daisy_bits = 40;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shapool_host_spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : shapool_sck_gen
// Description : SCK divider plus bit counter shared by the load and readback
//               phases. Produces rise/fall/sample strobes (valid in the cycle
//               before the SCK edge takes effect) and a last-bit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shapool_sck_gen #(
    parameter  int SCK_DIV  = 4,
    parameter  int MAX_BITS = 352,
    localparam int DIV_W    = $clog2(SCK_DIV + 1),
    localparam int BIT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_run,
    input  logic [BIT_W-1:0] i_num_bits,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_sample,
    output logic             o_last_bit
);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_sck;
    logic             w_tick;

    // Final clk cycle of the current SCK half-period
    assign w_tick = i_run && (r_div_cnt == DIV_W'(SCK_DIV - 1));

    // Divider wraps exactly at SCK_DIV-1; bits are counted on each SCK fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (!i_run) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            if (r_sck) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_rise     = w_tick & ~r_sck;
    assign o_fall     = w_tick &  r_sck;
    // Last clk cycle of the SCK-high phase coincides with the fall strobe
    assign o_sample   = w_tick &  r_sck;
    assign o_last_bit = (r_bit_cnt == (i_num_bits - BIT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/shapool_host_spi.sv
`default_nettype none
// ============================================================================
// Module      : shapool_host_spi
// Description : Host-side SPI initiator for a shapool chain. Shifts one job
//               word out on the global bus, waits for open-drain READY, then
//               reads the result word back over the daisy chain.
// Revision    : 1.0 - initial release
// ============================================================================
module shapool_host_spi
    import shapool_host_spi_pkg::*;
#(
    parameter int JOB_BITS   = c_default_job_bits,
    parameter int DAISY_BITS = c_default_daisy_bits,
    parameter int SCK_DIV    = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic [JOB_BITS-1:0]   job_data_in,
    input  logic                  job_valid_in,
    output logic                  job_ready_out,
    input  logic                  abort_in,
    output logic [DAISY_BITS-1:0] result_data_out,
    output logic                  result_valid_out,
    output logic                  sck0_out,
    output logic                  sdo0_out,
    output logic                  cs0_n_out,
    output logic                  sck1_out,
    output logic                  sdo1_out,
    output logic                  cs1_n_out,
    input  logic                  sdi1_in,
    input  logic                  ready_n_in
);

    localparam int c_max_bits = max_int(JOB_BITS, DAISY_BITS);
    localparam int c_bit_w    = $clog2(c_max_bits + 1);
    localparam int c_gap_w    = $clog2(2 * SCK_DIV + 1);

    host_state_t           r_state;
    logic [JOB_BITS-1:0]   r_job_sr;
    logic [DAISY_BITS-1:0] r_cap;
    logic [c_gap_w-1:0]    r_gap_cnt;
    logic                  r_ready_meta;
    logic                  r_ready_sync;
    logic                  r_job_ready;
    logic [DAISY_BITS-1:0] r_result_data;
    logic                  r_result_valid;
    logic                  r_sck0;
    logic                  r_sdo0;
    logic                  r_cs0_n;
    logic                  r_sck1;
    logic                  r_cs1_n;

    logic                  w_run;
    logic [c_bit_w-1:0]    w_num_bits;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_sample;
    logic                  w_last_bit;

    // The generator only runs while a bus is actively clocking
    assign w_run      = (r_state == ST_LOAD) || (r_state == ST_READ);
    assign w_num_bits = (r_state == ST_READ) ? c_bit_w'(DAISY_BITS) : c_bit_w'(JOB_BITS);

    shapool_sck_gen #(
        .SCK_DIV  (SCK_DIV),
        .MAX_BITS (c_max_bits)
    ) u_sck_gen (
        .clk        (clk_in),
        .rst_n      (reset_n_in),
        .i_run      (w_run),
        .i_num_bits (w_num_bits),
        .o_rise     (w_rise),
        .o_fall     (w_fall),
        .o_sample   (w_sample),
        .o_last_bit (w_last_bit)
    );

    // Two-flop synchroniser for the asynchronous open-drain READY line
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_ready_meta <= 1'b1;
            r_ready_sync <= 1'b1;
        end else begin
            r_ready_meta <= ready_n_in;
            r_ready_sync <= r_ready_meta;
        end
    end

    // Transfer sequencer with registered bus and handshake outputs
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state        <= ST_IDLE;
            r_job_sr       <= '0;
            r_cap          <= '0;
            r_gap_cnt      <= '0;
            r_job_ready    <= 1'b1;
            r_result_data  <= '0;
            r_result_valid <= 1'b0;
            r_sck0         <= 1'b0;
            r_sdo0         <= 1'b0;
            r_cs0_n        <= 1'b1;
            r_sck1         <= 1'b0;
            r_cs1_n        <= 1'b1;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (job_valid_in && r_job_ready) begin
                        r_job_sr    <= job_data_in;
                        r_sdo0      <= job_data_in[JOB_BITS-1];
                        r_cs0_n     <= 1'b0;
                        r_job_ready <= 1'b0;
                        r_state     <= ST_LOAD;
                    end else begin
                        r_job_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_rise) begin
                        r_sck0 <= 1'b1;
                    end else if (w_fall) begin
                        r_sck0 <= 1'b0;
                        if (w_last_bit) begin
                            r_cs0_n   <= 1'b1;
                            r_sdo0    <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            // Next bit appears in the same cycle SCK falls
                            r_job_sr <= {r_job_sr[JOB_BITS-2:0], 1'b0};
                            r_sdo0   <= r_job_sr[JOB_BITS-2];
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == c_gap_w'(2 * SCK_DIV - 1)) begin
                        r_state <= ST_WAIT_READY;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                    end
                end
                ST_WAIT_READY: begin
                    // Abort takes priority over a simultaneous READY
                    if (abort_in) begin
                        r_state <= ST_IDLE;
                    end else if (!r_ready_sync) begin
                        r_cs1_n <= 1'b0;
                        r_cap   <= '0;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_sample) begin
                        r_cap <= {r_cap[DAISY_BITS-2:0], sdi1_in};
                    end
                    if (w_rise) begin
                        r_sck1 <= 1'b1;
                    end else if (w_fall) begin
                        r_sck1 <= 1'b0;
                        if (w_last_bit) begin
                            r_cs1_n <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_result_data  <= r_cap;
                    r_result_valid <= 1'b1;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_ready_out    = r_job_ready;
    assign result_data_out  = r_result_data;
    assign result_valid_out = r_result_valid;
    assign sck0_out         = r_sck0;
    assign sdo0_out         = r_sdo0;
    assign cs0_n_out        = r_cs0_n;
    assign sck1_out         = r_sck1;
    assign sdo1_out         = 1'b0;
    assign cs1_n_out        = r_cs1_n;

endmodule
`default_nettype wire

// File: tb/tb_shapool_host_spi.sv
`default_nettype none
// ============================================================================
// Module      : tb_shapool_host_spi
// Description : Directed self-checking bench for shapool_host_spi. Instance A
//               uses an 8-bit job with SCK_DIV=2; instance B uses the default
//               widths with SCK_DIV=1. Simple device models capture the load
//               stream and return a readback word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shapool_host_spi;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: JOB_BITS=8, SCK_DIV=2 ----------------
    logic [7:0]  a_job_data;
    logic        a_job_valid, a_job_ready, a_abort, a_valid;
    logic [39:0] a_result;
    logic        a_sck0, a_sdo0, a_cs0_n, a_sck1, a_sdo1, a_cs1_n, a_sdi1, a_ready_n;
    logic [39:0] a_dev_word;
    logic [7:0]  a_load_sr = '0;
    int          a_rise_cnt = 0, a_fall_cnt = 0, a_valid_cnt = 0, a_accept_cnt = 0;

    shapool_host_spi #(.JOB_BITS(8), .DAISY_BITS(40), .SCK_DIV(2)) dut_a (
        .clk_in(clk), .reset_n_in(rst_n),
        .job_data_in(a_job_data), .job_valid_in(a_job_valid), .job_ready_out(a_job_ready),
        .abort_in(a_abort), .result_data_out(a_result), .result_valid_out(a_valid),
        .sck0_out(a_sck0), .sdo0_out(a_sdo0), .cs0_n_out(a_cs0_n),
        .sck1_out(a_sck1), .sdo1_out(a_sdo1), .cs1_n_out(a_cs1_n),
        .sdi1_in(a_sdi1), .ready_n_in(a_ready_n)
    );

    // ---------------- instance B: default widths, SCK_DIV=1 ------------
    logic [351:0] b_job_data, b_job, b_load_sr = '0;
    logic         b_job_valid, b_job_ready, b_abort, b_valid;
    logic [39:0]  b_result;
    logic         b_sck0, b_sdo0, b_cs0_n, b_sck1, b_sdo1, b_cs1_n, b_sdi1, b_ready_n;
    logic [39:0]  b_dev_word;
    int           b_rise_cnt = 0, b_fall_cnt = 0;

    shapool_host_spi #(.JOB_BITS(352), .DAISY_BITS(40), .SCK_DIV(1)) dut_b (
        .clk_in(clk), .reset_n_in(rst_n),
        .job_data_in(b_job_data), .job_valid_in(b_job_valid), .job_ready_out(b_job_ready),
        .abort_in(b_abort), .result_data_out(b_result), .result_valid_out(b_valid),
        .sck0_out(b_sck0), .sdo0_out(b_sdo0), .cs0_n_out(b_cs0_n),
        .sck1_out(b_sck1), .sdo1_out(b_sdo1), .cs1_n_out(b_cs1_n),
        .sdi1_in(b_sdi1), .ready_n_in(b_ready_n)
    );

    // Device side of the global bus: sample sdo0 on every SCK rise
    always @(posedge a_sck0) begin
        a_load_sr  <= {a_load_sr[6:0], a_sdo0};
        a_rise_cnt <= a_rise_cnt + 1;
    end
    always @(posedge b_sck0) begin
        b_load_sr  <= {b_load_sr[350:0], b_sdo0};
        b_rise_cnt <= b_rise_cnt + 1;
    end

    // Device side of the daisy bus: shift the next bit after each SCK fall
    always @(negedge a_sck1 or posedge a_cs1_n) begin
        if (a_cs1_n) a_fall_cnt <= 0;
        else         a_fall_cnt <= a_fall_cnt + 1;
    end
    always @(negedge b_sck1 or posedge b_cs1_n) begin
        if (b_cs1_n) b_fall_cnt <= 0;
        else         b_fall_cnt <= b_fall_cnt + 1;
    end
    assign a_sdi1 = (a_fall_cnt < 40) ? a_dev_word[39 - a_fall_cnt] : 1'b0;
    assign b_sdi1 = (b_fall_cnt < 40) ? b_dev_word[39 - b_fall_cnt] : 1'b0;

    // Handshake observers for instance A
    always @(posedge clk) begin
        if (a_valid)                    a_valid_cnt  <= a_valid_cnt + 1;
        if (a_job_valid && a_job_ready) a_accept_cnt <= a_accept_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int k;
        int r0;
        int acc0;
        int lows;

        rst_n = 1'b0;
        a_job_data = '0; a_job_valid = 1'b0; a_abort = 1'b0; a_ready_n = 1'b1;
        b_job_data = '0; b_job_valid = 1'b0; b_abort = 1'b0; b_ready_n = 1'b1;
        a_dev_word = 40'h12345678_03;
        b_dev_word = 40'hA55A3CC3_7F;
        for (int i = 0; i < 11; i++) begin
            b_job[i*32 +: 32] = (32'h01000193 * 32'(i + 1)) ^ 32'h811C9DC5;
        end

        // ---------------- reset state ----------------
        step(3);
        check("rst_cs0_n",  64'(a_cs0_n), 64'd1);
        check("rst_cs1_n",  64'(a_cs1_n), 64'd1);
        check("rst_sck0",   64'(a_sck0), 64'd0);
        check("rst_sck1",   64'(a_sck1), 64'd0);
        check("rst_sdo0",   64'(a_sdo0), 64'd0);
        check("rst_ready",  64'(a_job_ready), 64'd1);
        check("rst_valid",  64'(a_valid), 64'd0);
        check("rst_result", 64'(a_result), 64'd0);
        check("rst_b_cs0_n", 64'(b_cs0_n), 64'd1);
        rst_n = 1'b1;
        step(2);

        // ---------------- job 0xA5 on instance A ----------------
        r0 = a_rise_cnt;
        a_job_data = 8'hA5; a_job_valid = 1'b1;
        step(1);
        a_job_valid = 1'b0;
        check("a_accept_cs0_n", 64'(a_cs0_n), 64'd0);
        check("a_accept_sdo0",  64'(a_sdo0), 64'd1);
        check("a_busy_ready",   64'(a_job_ready), 64'd0);
        step(1);
        check("a_sck0_low_n2",  64'(a_sck0), 64'd0);
        step(1);
        check("a_sck0_rise_n3", 64'(a_sck0), 64'd1);
        n = 2;
        while (a_cs0_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("a_load_cycles", 64'(n), 64'd32);
        check("a_load_bits",   64'(a_load_sr), 64'hA5);
        check("a_load_rises",  64'(a_rise_cnt - r0), 64'd8);
        check("a_gap_sck0",    64'(a_sck0), 64'd0);
        step(14);
        a_ready_n = 1'b0;
        k = 0;
        do begin step(1); k++; end while (a_cs1_n === 1'b1 && k < 20);
        check("a_ready_latency", 64'(k), 64'd3);
        a_ready_n = 1'b1;
        check("a_read_sdo1", 64'(a_sdo1), 64'd0);
        n = 0;
        while (a_cs1_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("a_read_cycles", 64'(n), 64'd160);
        check("a_valid_early", 64'(a_valid), 64'd0);
        step(1);
        check("a_valid_pulse", 64'(a_valid), 64'd1);
        check("a_result",      64'(a_result), 64'h12345678_03);
        check("a_ready_late",  64'(a_job_ready), 64'd0);
        step(1);
        check("a_valid_end",   64'(a_valid), 64'd0);
        check("a_ready_back",  64'(a_job_ready), 64'd1);
        check("a_valid_count", 64'(a_valid_cnt), 64'd1);

        // ---------------- abort while waiting for READY ----------------
        a_job_data = 8'h3C; a_job_valid = 1'b1;
        step(1);
        a_job_valid = 1'b0;
        n = 0;
        while (a_cs0_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("ab_load_cycles", 64'(n), 64'd32);
        step(6);
        a_abort = 1'b1;
        step(1);
        a_abort = 1'b0;
        check("ab_ready_w1", 64'(a_job_ready), 64'd0);
        step(1);
        check("ab_ready_w2", 64'(a_job_ready), 64'd1);
        a_ready_n = 1'b0;
        lows = 0;
        repeat (10) begin step(1); if (a_cs1_n !== 1'b1) lows++; end
        a_ready_n = 1'b1;
        check("ab_cs1_idle",  64'(lows), 64'd0);
        check("ab_no_valid",  64'(a_valid_cnt), 64'd1);

        // ---------------- abort and READY in the same cycle ----------------
        step(4);
        a_job_data = 8'hC3; a_job_valid = 1'b1;
        step(1);
        a_job_valid = 1'b0;
        n = 0;
        while (a_cs0_n === 1'b0 && n < 5000) begin step(1); n++; end
        step(5);
        a_ready_n = 1'b0;
        step(2);
        a_abort = 1'b1;
        step(1);
        a_abort = 1'b0;
        lows = (a_cs1_n !== 1'b1) ? 1 : 0;
        repeat (10) begin step(1); if (a_cs1_n !== 1'b1) lows++; end
        a_ready_n = 1'b1;
        check("tie_cs1_idle", 64'(lows), 64'd0);
        check("tie_no_valid", 64'(a_valid_cnt), 64'd1);
        check("tie_ready",    64'(a_job_ready), 64'd1);

        // ---------------- job_valid held high through a transfer ----------------
        step(4);
        a_dev_word = 40'hCAFEF00D_7E;
        acc0 = a_accept_cnt;
        a_job_data = 8'h5A; a_job_valid = 1'b1;
        step(1);
        n = 0;
        while (a_cs0_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("hold_load_bits", 64'(a_load_sr), 64'h5A);
        step(14);
        a_ready_n = 1'b0;
        k = 0;
        while (a_cs1_n === 1'b1 && k < 50) begin step(1); k++; end
        a_ready_n = 1'b1;
        n = 0;
        while (a_cs1_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("hold_read_cycles", 64'(n), 64'd160);
        step(1);
        check("hold_valid",   64'(a_valid), 64'd1);
        check("hold_result",  64'(a_result), 64'hCAFEF00D_7E);
        check("hold_accepts", 64'(a_accept_cnt - acc0), 64'd1);
        step(1);
        check("hold_ready",    64'(a_job_ready), 64'd1);
        check("hold_accepts2", 64'(a_accept_cnt - acc0), 64'd1);
        step(1);
        check("hold_second",   64'(a_accept_cnt - acc0), 64'd2);
        check("hold_cs0_n",    64'(a_cs0_n), 64'd0);
        a_job_valid = 1'b0;

        // ---------------- instance B: full-width round trip, SCK_DIV=1 ----------------
        r0 = b_rise_cnt;
        b_job_data = b_job; b_job_valid = 1'b1;
        step(1);
        b_job_valid = 1'b0;
        check("b_accept_sdo0", 64'(b_sdo0), 64'(b_job[351]));
        n = 0;
        while (b_cs0_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("b_load_cycles", 64'(n), 64'd704);
        check("b_load_rises",  64'(b_rise_cnt - r0), 64'd352);
        check("b_load_data",   64'(b_load_sr == b_job), 64'd1);
        step(6);
        b_ready_n = 1'b0;
        k = 0;
        do begin step(1); k++; end while (b_cs1_n === 1'b1 && k < 20);
        check("b_ready_latency", 64'(k), 64'd3);
        b_ready_n = 1'b1;
        check("b_read_sdo1", 64'(b_sdo1), 64'd0);
        n = 0;
        while (b_cs1_n === 1'b0 && n < 5000) begin step(1); n++; end
        check("b_read_cycles", 64'(n), 64'd80);
        step(1);
        check("b_valid",  64'(b_valid), 64'd1);
        check("b_result", 64'(b_result), 64'hA55A3CC3_7F);

        // ---------------- asynchronous reset in the middle of a load ----------------
        step(2);
        r0 = b_rise_cnt;
        b_job_data = ~b_job; b_job_valid = 1'b1;
        step(1);
        b_job_valid = 1'b0;
        n = 0;
        while ((b_rise_cnt - r0) < 100 && n < 5000) begin step(1); n++; end
        check("mid_cs0_n_active", 64'(b_cs0_n), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs0_n",  64'(b_cs0_n), 64'd1);
        check("mid_rst_sck0",   64'(b_sck0), 64'd0);
        check("mid_rst_sdo0",   64'(b_sdo0), 64'd0);
        check("mid_rst_ready",  64'(b_job_ready), 64'd1);
        check("mid_rst_valid",  64'(b_valid), 64'd0);
        check("mid_rst_a_cs0_n", 64'(a_cs0_n), 64'd1);
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
